apb_regfile_slave: RTL

//  Parametrised APB slave fronting a DEPTH-entry register file, the next generation of the team's APB slave.

---
 rtl/apb_regfile_slave_pkg.sv | 18 +
 rtl/apb_regfile_slave_if.sv | 29 ++
 rtl/apb_regfile_slave_reg_array.sv | 37 +++
 rtl/apb_regfile_slave.sv | 116 +++++++++++
 4 files changed

// File: rtl/apb_regfile_slave_pkg.sv
// Shared types for the APB register-file slave.
// The state enum is also used by the APB assertion module that binds onto
// the slave's exported state port, so its encoding is fixed.
package apb_regfile_slave_pkg;

    // SETUP_PHASE is reserved: setup is recognised from IDLE_PHASE directly,
    // so the slave never sits in encoding 1.
    typedef enum logic [1:0] {
        IDLE_PHASE  = 2'd0,
        SETUP_PHASE = 2'd1,
        W_PHASE     = 2'd2,
        R_PHASE     = 2'd3
    } apb_state_e;

    // Wide enough for WAIT_STATES up to 15.
    localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle between the bridge (master) and the register-file slave.
//   p_sel/p_enable/p_write/p_addr/wr_data/p_strb : master -> slave
//   rd_data/p_ready/p_slverr                      : slave -> master
interface apb_regfile_slave_if #(
    parameter int unsigned A_WIDTH = 8,
    parameter int unsigned D_WIDTH = 32
);
    localparam int unsigned STRB_W = D_WIDTH / 8;

    logic               p_sel;
    logic               p_enable;
    logic               p_write;
    logic [A_WIDTH-1:0] p_addr;
    logic [D_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]  p_strb;
    logic [D_WIDTH-1:0] rd_data;
    logic               p_ready;
    logic               p_slverr;

    modport master (
        output p_sel, p_enable, p_write, p_addr, wr_data, p_strb,
        input  rd_data, p_ready, p_slverr
    );

    modport slave (
        input  p_sel, p_enable, p_write, p_addr, wr_data, p_strb,
        output rd_data, p_ready, p_slverr
    );
endinterface

// File: rtl/apb_regfile_slave_reg_array.sv
// Register storage for the APB slave.
// Ports:
//   p_clk, p_rst : clock, synchronous active-high reset (all regs -> RESET_VAL)
//   we           : write enable for the selected register
//   idx          : register index (write and combinational read)
//   strb         : byte strobes, only strobed bytes are written
//   wdata        : write data
//   rdata        : combinational read of register idx
module apb_reg_array #(
    parameter int unsigned        DEPTH     = 16,
    parameter int unsigned        D_WIDTH   = 32,
    parameter logic [D_WIDTH-1:0] RESET_VAL = 'h12
) (
    input  logic                       p_clk,
    input  logic                       p_rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [D_WIDTH/8-1:0]       strb,
    input  logic [D_WIDTH-1:0]         wdata,
    output logic [D_WIDTH-1:0]         rdata
);
    localparam int unsigned STRB_W = D_WIDTH / 8;

    logic [DEPTH-1:0][D_WIDTH-1:0] mem;

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            mem <= {DEPTH{RESET_VAL}};
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave fronting a DEPTH-entry register file with byte-strobed writes,
// programmable wait states and PSLVERR decode (out of range, misaligned,
// write to read-only register).
// Ports:
//   p_clk, p_rst : clock, synchronous active-high reset
//   bus          : APB slave modport (select/enable/write/addr/data/strobe in,
//                  rd_data/p_ready/p_slverr out, all outputs combinational)
//   state        : FSM state, exported for bound protocol assertions
module apb_regfile_slave
    import apb_regfile_slave_pkg::*;
#(
    parameter int unsigned        A_WIDTH     = 8,
    parameter int unsigned        D_WIDTH     = 32,
    parameter int unsigned        DEPTH       = 16,
    parameter int unsigned        WAIT_STATES = 0,
    parameter logic [D_WIDTH-1:0] RESET_VAL   = 'h12,
    parameter logic [DEPTH-1:0]   RO_MASK     = '0
) (
    input  logic                p_clk,
    input  logic                p_rst,
    apb_regfile_slave_if.slave  bus,
    output apb_state_e          state
);
    localparam int unsigned STRB_W = D_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);

    apb_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [A_WIDTH-1:0] idx;
    logic [IDX_W-1:0]   reg_idx;
    logic               idx_ok, misaligned, ro_hit, err;
    logic               in_access, ready, complete, we;
    logic [D_WIDTH-1:0] reg_rdata, rd_mux;

    // Address decode. Masking with STRB_W-1 avoids a zero-width slice when
    // the bus is a single byte wide.
    assign idx        = bus.p_addr >> OFF_W;
    assign idx_ok     = {1'b0, idx} < (A_WIDTH+1)'(DEPTH);
    assign reg_idx    = idx_ok ? idx[IDX_W-1:0] : '0;
    assign misaligned = (bus.p_addr & A_WIDTH'(STRB_W - 1)) != '0;
    // Read-only mask only consulted for in-range indices.
    assign ro_hit     = idx_ok && bus.p_write && RO_MASK[reg_idx];
    assign err        = !idx_ok || misaligned || ro_hit;

    // State register.
    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            state_q    <= IDLE_PHASE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic. Setup is recognised from IDLE, so a completion
    // followed immediately by a new setup cycle costs no dead cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE_PHASE: begin
                wait_cnt_d = '0;
                if (bus.p_sel && !bus.p_enable)
                    state_d = bus.p_write ? W_PHASE : R_PHASE;
            end
            W_PHASE, R_PHASE: begin
                if (!bus.p_sel || ready) begin
                    // abort or completion
                    state_d    = IDLE_PHASE;
                    wait_cnt_d = '0;
                end else if (bus.p_enable) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE_PHASE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        in_access = (state_q == W_PHASE) || (state_q == R_PHASE);
        ready     = in_access && bus.p_enable &&
                    (wait_cnt_q == WAIT_CNT_W'(WAIT_STATES));
        complete  = bus.p_sel && ready;
        we        = complete && (state_q == W_PHASE) && !err;
        rd_mux    = '0;
        // Errored reads return the reset value rather than zero.
        if ((state_q == R_PHASE) && ready)
            rd_mux = err ? RESET_VAL : reg_rdata;
    end

    assign bus.p_ready  = ready;
    assign bus.p_slverr = ready && err;
    assign bus.rd_data  = rd_mux;
    assign state        = state_q;

    apb_reg_array #(
        .DEPTH     (DEPTH),
        .D_WIDTH   (D_WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_regs (
        .p_clk (p_clk),
        .p_rst (p_rst),
        .we    (we),
        .idx   (reg_idx),
        .strb  (bus.p_strb),
        .wdata (bus.wr_data),
        .rdata (reg_rdata)
    );
endmodule
